// File: rtl/wb_writer.sv
// wb_writer
// Writeback-side producer for the register file write port. ALU results are
// buffered in a small FIFO; load responses bypass it and always win the
// single write slot. Load data is byte/half extracted and extended here, and
// a per-register scoreboard tracks loads that are issued but not yet written.
//
// Ports
//   i_clk, i_reset                   clock, asynchronous active-high reset
//   i_alu_valid/_rd/_data            ALU result; accepted when o_alu_ready
//   o_alu_ready                      ALU FIFO not full
//   i_ld_valid/_rd/_data             load response (never backpressured)
//   i_ld_funct3, i_ld_addr_lo        load type and byte offset
//   i_ld_issue, i_ld_issue_rd        load issued; mark destination pending
//   o_busy                           pending-load scoreboard (bit 0 always 0)
//   o_rd_addr/_data/_wren            registered register file write
module wb_writer #(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int XLEN           = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_ld_valid,
    input  logic [4:0]      i_ld_rd,
    input  logic [XLEN-1:0] i_ld_data,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_addr_lo,
    input  logic            i_ld_issue,
    input  logic [4:0]      i_ld_issue_rd,
    output logic [31:0]     o_busy,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren
);

    localparam int PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 5 + XLEN;

    // ------------------------------------------------------------------
    // ALU result FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] fifo_mem [ALU_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // Ready depends only on the occupancy so it never combinationally
    // follows the load side.
    assign o_alu_ready = (count_reg != CNT_W'(ALU_FIFO_DEPTH));
    assign push        = i_alu_valid && o_alu_ready;
    assign pop         = !i_ld_valid && (count_reg != '0);
    assign head        = fifo_mem[rd_ptr_reg];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {i_alu_rd, i_alu_data};
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_ext;

    assign ld_shifted = i_ld_data >> {i_ld_addr_lo, 3'b000};

    always_comb begin
        ld_ext = i_ld_data;
        case (i_ld_funct3)
            3'b000:  ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shifted[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shifted[15:0]};
            default: ld_ext = i_ld_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-slot arbitration and output register
    // ------------------------------------------------------------------
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = head[ENT_W-1:XLEN];
        sel_data  = head[XLEN-1:0];
        if (i_ld_valid) begin
            sel_valid = 1'b1;
            sel_rd    = i_ld_rd;
            sel_data  = ld_ext;
        end else if (pop) begin
            sel_valid = 1'b1;
        end
    end

    // A write to x0 still consumes the entry and updates addr/data, but
    // never asserts the enable.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else if (sel_valid) begin
            o_rd_wren <= (sel_rd != 5'd0);
            o_rd_addr <= sel_rd;
            o_rd_data <= sel_data;
        end else begin
            o_rd_wren <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-load scoreboard
    // ------------------------------------------------------------------
    logic [31:0] busy_reg, busy_next;

    assign busy_next[0] = 1'b0;

    // A new issue to the same register outranks the completing response,
    // since that register now has another load outstanding.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit, clr_bit;
            assign set_bit = i_ld_issue && (i_ld_issue_rd == 5'(gi));
            assign clr_bit = i_ld_valid && (i_ld_rd == 5'(gi));
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign o_busy = busy_reg;

endmodule

// File: tb/tb_wb_writer.sv
module tb_wb_writer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_ld_valid;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic [2:0]  i_ld_funct3;
    logic [1:0]  i_ld_addr_lo;
    logic        i_ld_issue;
    logic [4:0]  i_ld_issue_rd;
    logic [31:0] o_busy;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;

    wb_writer #(.ALU_FIFO_DEPTH(2), .XLEN(32)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_alu_valid   (i_alu_valid),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .o_alu_ready   (o_alu_ready),
        .i_ld_valid    (i_ld_valid),
        .i_ld_rd       (i_ld_rd),
        .i_ld_data     (i_ld_data),
        .i_ld_funct3   (i_ld_funct3),
        .i_ld_addr_lo  (i_ld_addr_lo),
        .i_ld_issue    (i_ld_issue),
        .i_ld_issue_rd (i_ld_issue_rd),
        .o_busy        (o_busy),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_wren     (o_rd_wren)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %-14s value 0x%08h", name, act);
        end else begin
            $display("FAIL %-14s got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b1;
        i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
        i_ld_valid = 0; i_ld_rd = 0; i_ld_data = 0;
        i_ld_funct3 = 0; i_ld_addr_lo = 0;
        i_ld_issue = 0; i_ld_issue_rd = 0;

        vecs[0] = '{3'b000, 2'd0, 32'h0000_0001};  // LB@0
        vecs[1] = '{3'b000, 2'd2, 32'hFFFF_FFFF};  // LB@2
        vecs[2] = '{3'b100, 2'd3, 32'h0000_0080};  // LBU@3
        vecs[3] = '{3'b001, 2'd2, 32'hFFFF_80FF};  // LH@2
        vecs[4] = '{3'b101, 2'd0, 32'h0000_7F01};  // LHU@0
        vecs[5] = '{3'b010, 2'd0, 32'h80FF_7F01};  // LW
        vecs[6] = '{3'b000, 2'd1, 32'h0000_007F};  // LB@1
        vecs[7] = '{3'b101, 2'd2, 32'h0000_80FF};  // LHU@2
        vecs[8] = '{3'b001, 2'd3, 32'h0000_0080};  // LH@3 misaligned
        vecs[9] = '{3'b011, 2'd1, 32'h80FF_7F01};  // undefined funct3

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_wren",  {31'd0, o_rd_wren}, 32'd0);
        chk("rst_addr",  {27'd0, o_rd_addr}, 32'd0);
        chk("rst_data",  o_rd_data, 32'd0);
        chk("rst_busy",  o_busy, 32'd0);
        i_reset = 1'b0;
        chk("rst_ready", {31'd0, o_alu_ready}, 32'd1);

        // ---------------- single ALU write ----------------
        i_alu_valid = 1; i_alu_rd = 5; i_alu_data = 32'h1234_5678;
        tick();
        i_alu_valid = 0;
        chk("alu_push_wren", {31'd0, o_rd_wren}, 32'd0);
        tick();
        chk("alu_wren", {31'd0, o_rd_wren}, 32'd1);
        chk("alu_addr", {27'd0, o_rd_addr}, 32'd5);
        chk("alu_data", o_rd_data, 32'h1234_5678);

        // ---------------- reset mid-burst ----------------
        i_alu_valid = 1; i_alu_rd = 6; i_alu_data = 32'h66;
        i_ld_issue = 1; i_ld_issue_rd = 3;
        tick();
        i_alu_rd = 7; i_alu_data = 32'h77; i_ld_issue = 0;
        tick();
        chk("burst_addr", {27'd0, o_rd_addr}, 32'd6);
        chk("burst_busy", o_busy, 32'h0000_0008);
        i_alu_valid = 0;
        i_reset = 1'b1;
        #1;
        chk("arst_wren", {31'd0, o_rd_wren}, 32'd0);
        chk("arst_busy", o_busy, 32'd0);
        chk("arst_addr", {27'd0, o_rd_addr}, 32'd0);
        tick();
        i_reset = 1'b0;
        chk("arst_ready", {31'd0, o_alu_ready}, 32'd1);
        tick();
        chk("arst_discard", {31'd0, o_rd_wren}, 32'd0);

        // ---------------- loads win over buffered ALU results ----------------
        i_ld_valid = 1; i_ld_rd = 9; i_ld_data = 32'h9999_0000; i_ld_funct3 = 3'b010; i_ld_addr_lo = 0;
        i_alu_valid = 1; i_alu_rd = 1; i_alu_data = 32'h101;
        tick();
        chk("arb_ld1", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'd9});
        i_alu_rd = 2; i_alu_data = 32'h102;
        tick();
        chk("arb_ld2", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'd9});
        i_alu_rd = 3; i_alu_data = 32'h103;
        chk("arb_full", {31'd0, o_alu_ready}, 32'd0);
        tick();
        chk("arb_ld3", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'd9});
        i_ld_valid = 0;
        chk("arb_full2", {31'd0, o_alu_ready}, 32'd0);
        tick();
        chk("arb_alu1", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'd1});
        chk("arb_alu1_d", o_rd_data, 32'h101);
        chk("arb_ready", {31'd0, o_alu_ready}, 32'd1);
        tick();
        i_alu_valid = 0;
        chk("arb_alu2", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'd2});
        tick();
        chk("arb_alu3", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'd3});
        chk("arb_alu3_d", o_rd_data, 32'h103);
        tick();
        chk("arb_idle", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b0, 5'd3});

        // ---------------- load extraction table ----------------
        i_ld_data = 32'h80FF_7F01;
        for (int i = 0; i < 10; i++) begin
            i_ld_valid = 1; i_ld_rd = 5'(10 + i);
            i_ld_funct3 = vecs[i].f3; i_ld_addr_lo = vecs[i].lo;
            tick();
            chk($sformatf("ld_vec%0d_addr", i), {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'(10 + i)});
            chk($sformatf("ld_vec%0d_data", i), o_rd_data, vecs[i].exp);
        end
        i_ld_valid = 0;

        // ---------------- scoreboard ----------------
        i_ld_funct3 = 3'b010; i_ld_addr_lo = 0;
        i_ld_issue = 1; i_ld_issue_rd = 7;
        tick();
        i_ld_issue = 0;
        chk("sb_set", o_busy, 32'h0000_0080);
        tick();
        chk("sb_hold", o_busy, 32'h0000_0080);
        i_ld_valid = 1; i_ld_rd = 7; i_ld_data = 32'h7777;
        tick();
        i_ld_valid = 0;
        chk("sb_clr_wren", {31'd0, o_rd_wren}, 32'd1);
        chk("sb_clr", o_busy, 32'd0);
        i_ld_issue = 1; i_ld_issue_rd = 7;
        tick();
        i_ld_valid = 1; i_ld_rd = 7;
        tick();
        i_ld_issue = 0; i_ld_valid = 0;
        chk("sb_setwins", o_busy, 32'h0000_0080);
        chk("sb_sw_wren", {31'd0, o_rd_wren}, 32'd1);
        i_ld_valid = 1; i_ld_rd = 7;
        tick();
        i_ld_valid = 0;
        chk("sb_clr2", o_busy, 32'd0);
        i_ld_issue = 1; i_ld_issue_rd = 0;
        tick();
        i_ld_issue = 0;
        chk("sb_x0", o_busy, 32'd0);
        i_ld_issue = 1; i_ld_issue_rd = 4;
        i_alu_valid = 1; i_alu_rd = 4; i_alu_data = 32'h44;
        tick();
        i_ld_issue = 0; i_alu_valid = 0;
        tick();
        chk("sb_alu_wren", {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, 5'd4});
        chk("sb_alu_keep", o_busy, 32'h0000_0010);
        i_ld_valid = 1; i_ld_rd = 4;
        tick();
        i_ld_valid = 0;

        // ---------------- writes to x0 ----------------
        i_alu_valid = 1; i_alu_rd = 0; i_alu_data = 32'hDEAD_BEEF;
        tick();
        i_alu_valid = 0;
        tick();
        chk("x0_alu_wren", {31'd0, o_rd_wren}, 32'd0);
        chk("x0_alu_data", o_rd_data, 32'hDEAD_BEEF);
        i_ld_valid = 1; i_ld_rd = 0; i_ld_data = 32'h1111_2222;
        tick();
        i_ld_valid = 0;
        chk("x0_ld_wren", {31'd0, o_rd_wren}, 32'd0);
        chk("x0_ld_data", o_rd_data, 32'h1111_2222);
        chk("x0_busy", o_busy, 32'd0);
        tick();
        chk("x0_hold", o_rd_data, 32'h1111_2222);

        // ---------------- FIFO wrap with interleaved loads ----------------
        begin
            logic [36:0] exp_q[$];
            logic [36:0] head;
            int cnt = 0;
            int k = 0;
            int m = 0;
            bit ld, psh, pp;
            for (int cyc = 0; cyc < 40 && m < 6; cyc++) begin
                ld = (cyc % 3 == 1);
                i_ld_valid = ld; i_ld_rd = 9; i_ld_data = 32'h900 + cyc; i_ld_funct3 = 3'b010;
                i_alu_valid = (k < 6); i_alu_rd = 5'(20 + k); i_alu_data = 32'hA0 + k;
                chk($sformatf("wrap_rdy%0d", cyc), {31'd0, o_alu_ready}, {31'd0, (cnt < 2)});
                psh = (k < 6) && (cnt < 2);
                pp  = !ld && (cnt > 0);
                head = '0;
                if (pp) head = exp_q.pop_front();
                if (psh) begin
                    exp_q.push_back({5'(20 + k), 32'hA0 + k});
                    k++;
                end
                cnt = cnt + (psh ? 1 : 0) - (pp ? 1 : 0);
                tick();
                if (ld) begin
                    chk($sformatf("wrap_ld%0d", cyc), {o_rd_wren, o_rd_addr, o_rd_data[25:0]},
                        {1'b1, 5'd9, 26'(32'h900 + cyc)});
                end else if (pp) begin
                    chk($sformatf("wrap_alu%0d_a", m), {26'd0, o_rd_wren, o_rd_addr}, {26'd0, 1'b1, head[36:32]});
                    chk($sformatf("wrap_alu%0d_d", m), o_rd_data, head[31:0]);
                    m++;
                end else begin
                    chk($sformatf("wrap_idle%0d", cyc), {31'd0, o_rd_wren}, 32'd0);
                end
            end
            i_ld_valid = 0; i_alu_valid = 0;
            chk("wrap_count", m, 32'd6);
            tick();
            chk("wrap_drained", {31'd0, o_rd_wren}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
